// File: rtl/darkroom_spi_receiver.sv
// DarkRoom SPI frame receiver: 32-byte SPI mode-0 frames unpacked into 8x32-bit words per bank, read over Avalon-MM.
// Latency: pin edge seen 3 clocks later; commit on the 4th clock after ss_n_i rises; reads take one wait state.
// Backpressure: none on SPI (the transmitter free-runs); Avalon reads always stall exactly one cycle.
module darkroom_spi_receiver #(
  parameter int NUMBER_OF_SPI_FRAMES = 1,
  parameter int GAP_CYCLES           = 4096
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        sck_i,
  input  logic        ss_n_i,
  input  logic        mosi_i,
  input  logic [6:0]  address,
  input  logic        read,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic        frame_valid_o,
  output logic [3:0]  frame_index_o
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t            state;
  logic [2:0]        sck_sync;
  logic [2:0]        ss_sync;
  logic [1:0]        mosi_sync;
  logic              sck_rise;
  logic              ss_fall;
  logic              ss_rise;
  logic              mosi_bit;
  logic [2:0]        bit_cnt;
  logic [5:0]        byte_cnt;
  logic              overflow;
  logic [6:0]        byte_reg;
  logic [31:0][7:0]  shadow;
  logic [7:0][31:0]  bank [NUMBER_OF_SPI_FRAMES];
  logic [3:0]        frame_idx;
  logic [15:0]       frame_count;
  logic [7:0]        error_count;
  logic [GW-1:0]     gap_cnt;
  logic [31:0]       rd_word;

  // Synchronize the asynchronous SPI pins; ss_n idles high so a low ss_n at reset release reads as a falling edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync  <= 3'b000;
      ss_sync   <= 3'b111;
      mosi_sync <= 2'b00;
    end else begin
      sck_sync  <= {sck_sync[1:0], sck_i};
      ss_sync   <= {ss_sync[1:0], ss_n_i};
      mosi_sync <= {mosi_sync[0], mosi_i};
    end
  end

  // Registered edge pulses, with mosi delayed to stay aligned with the sck rising pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sck_rise <= 1'b0;
      ss_fall  <= 1'b0;
      ss_rise  <= 1'b0;
      mosi_bit <= 1'b0;
    end else begin
      sck_rise <= sck_sync[1] & ~sck_sync[2];
      ss_fall  <= ~ss_sync[1] & ss_sync[2];
      ss_rise  <= ss_sync[1] & ~ss_sync[2];
      mosi_bit <= mosi_sync[1];
    end
  end

  // Receive FSM: shift bytes into the shadow frame, commit clean 32-byte frames to the current bank, count bad ones.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      bit_cnt       <= 3'd0;
      byte_cnt      <= 6'd0;
      overflow      <= 1'b0;
      byte_reg      <= 7'd0;
      shadow        <= '0;
      for (int f = 0; f < NUMBER_OF_SPI_FRAMES; f++) bank[f] <= '0;
      frame_idx     <= 4'd0;
      frame_count   <= 16'd0;
      error_count   <= 8'd0;
      gap_cnt       <= '0;
      frame_valid_o <= 1'b0;
      frame_index_o <= 4'd0;
    end else begin
      frame_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (ss_fall) begin
            state    <= RECV;
            bit_cnt  <= 3'd0;
            byte_cnt <= 6'd0;
            overflow <= 1'b0;
            gap_cnt  <= '0;
          end else if (ss_sync[2]) begin
            // A long quiet period marks the start of a new burst.
            if (gap_cnt < GW'(GAP_CYCLES)) gap_cnt <= gap_cnt + 1'b1;
            else frame_idx <= 4'd0;
          end
        end
        RECV: begin
          if (ss_rise) begin
            state <= IDLE;
            if (byte_cnt == 6'd32 && bit_cnt == 3'd0 && !overflow) begin
              for (int f = 0; f < NUMBER_OF_SPI_FRAMES; f++)
                if (frame_idx == 4'(f)) bank[f] <= shadow;
              frame_index_o <= frame_idx;
              frame_valid_o <= 1'b1;
              frame_idx     <= (frame_idx == 4'(NUMBER_OF_SPI_FRAMES - 1)) ? 4'd0 : frame_idx + 4'd1;
              frame_count   <= frame_count + 16'd1;
            end else if (error_count != 8'hFF) begin
              error_count <= error_count + 8'd1;
            end
          end else if (sck_rise) begin
            byte_reg <= {byte_reg[5:0], mosi_bit};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (byte_cnt == 6'd32) begin
                overflow <= 1'b1;
              end else begin
                shadow[byte_cnt[4:0]] <= {byte_reg, mosi_bit};
                byte_cnt              <= byte_cnt + 6'd1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Avalon read mux: bank words, status word at 127, zero elsewhere.
  always_comb begin
    rd_word = 32'd0;
    if (address == 7'd127) begin
      rd_word = {frame_count, error_count, 4'b0000, frame_idx};
    end else begin
      for (int f = 0; f < NUMBER_OF_SPI_FRAMES; f++)
        if (address[6:3] == 4'(f)) rd_word = bank[f][address[2:0]];
    end
  end

  // One-wait-state read: capture data and raise waitrequest on the first cycle, drop it the next.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata    <= 32'd0;
      waitrequest <= 1'b0;
    end else if (read && !waitrequest) begin
      readdata    <= rd_word;
      waitrequest <= 1'b1;
    end else begin
      waitrequest <= 1'b0;
    end
  end

endmodule

// File: doc/darkroom_spi_receiver.md
# darkroom_spi_receiver

Receiving end of the DarkRoom sensor-data SPI link. The block sits on the host side, in place of the ESP8266, and accepts the 256-bit frames that DarkRoom's SPI transmitter emits: 8 bits per byte, SPI mode 0, 32 bytes per slave-select window. It unpacks each frame into eight 32-bit sensor words, double-buffers them per frame index, and exposes them through an Avalon-MM read slave with the same address map as DarkRoom.

## Interface
- NUMBER_OF_SPI_FRAMES, 1, number of 256-bit frames per burst (1..15); one bank per frame
- GAP_CYCLES, 4096, idle clock cycles with ss_n high after which the frame index returns to 0
- clock  in  1  system clock; all logic on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- sck_i  in  1  SPI clock from transmitter, asynchronous to clock
- ss_n_i  in  1  SPI slave select, active-low, asynchronous
- mosi_i  in  1  SPI data, asynchronous
- address  in  7  Avalon word address
- read  in  1  Avalon read strobe
- readdata  out  32  Avalon read data
- waitrequest  out  1  Avalon wait
- frame_valid_o  out  1  one-cycle pulse per committed frame
- frame_index_o  out  4  bank index written by the last commit

## Operation
- sck_i, ss_n_i and mosi_i each pass through a 2-flop synchronizer. A third flop on sck and ss_n provides edge detection.
- SPI mode 0: mosi is sampled on the sck rising edge, bits MSB first within each byte. sck edges while ss_n is high are ignored.
- Required sck high and low phases: at least 3 clock cycles each.
- Receive state machine:
  - IDLE -> RECV on ss_n falling edge. This clears the bit counter (3 bit), the byte counter (6 bit) and the overflow flag.
  - RECV: each sampled bit shifts into the byte register. On the 8th bit, the byte is written into the 256-bit shadow register at bits [8k+7:8k], where k is the byte counter, and the byte counter increments.
  - A 33rd byte sets the overflow flag. The shadow register is not written for that byte or any later one.
  - RECV -> IDLE on ss_n rising edge. A commit happens only if byte count == 32, bit count == 0 and overflow == 0. Any other ending increments the error counter and discards the frame.
- Byte/word mapping: byte 0 is the least significant byte of word 0, so word w = {byte 4w+3, 4w+2, 4w+1, 4w}.
- Commit behaviour:
  - The shadow register is copied to bank[frame_idx].
  - frame_index_o <= frame_idx and frame_valid_o pulses.
  - frame_idx increments, wrapping to 0 after NUMBER_OF_SPI_FRAMES-1.
  - frame_count increments, modulo 2^16.
- Gap counter: counts cycles while in IDLE with ss_n high and resets on every ss_n falling edge. When it reaches GAP_CYCLES, frame_idx returns to 0 and the counter saturates. This re-aligns the frame index to the start of each burst.
- error_count saturates at 255.
- Avalon address decode:
  - address/8 < NUMBER_OF_SPI_FRAMES: returns bank[address/8] word address%8.
  - address == 127: returns the status word {frame_count[15:0], error_count[7:0], 4'b0, frame_idx[3:0]}.
  - Any other address: returns 0.
- Reset mid-operation: the state machine goes to IDLE and all banks, counters, readdata and outputs clear. A frame in progress is lost, and a partial frame after reset release is counted as an error only if ss_n is low at release. The state machine waits for the next ss_n falling edge.

## Timing
- Reset values: readdata 0, waitrequest 0, frame_valid_o 0, frame_index_o 0, all banks 0, all counters 0, state IDLE.
- Input latency: a pin edge becomes visible to the internal logic 3 clock edges later (2 synchronizer flops plus the edge-detect flop).
- Commit: the bank write and the frame_valid_o pulse occur on the clock edge after ss_n rising is detected. That is the 4th clock edge after ss_n_i=1 is first sampled.
- Read handshake:
  - The cycle in which read is first seen with waitrequest=0: waitrequest is driven 1 and readdata is registered.
  - The next cycle: waitrequest=0 and readdata is valid.
  - Fixed latency of 1 wait state.
- A read that registers in the same cycle as a commit returns the pre-commit bank contents. The new contents are visible from the next read.
- Back-to-back frames: a gap of at least 8 clock cycles between ss_n rising and the next ss_n falling is required. The transmitter uses a gap of about 1023 cycles.

## Test plan
- Reset values: assert reset_n=0 mid-transfer, then release -> all outputs 0; a read of address 127 returns 0x00000000.
- Single valid frame: transmit bytes 0x00..0x1F with NUMBER_OF_SPI_FRAMES=1 -> frame_valid_o pulses once; address 0 reads 0x03020100, address 7 reads 0x1F1E1D1C, address 127 reads 0x00010000.
- Short and long frames: send 31 bytes, then 33 bytes -> no frame_valid_o pulse, bank contents unchanged, error_count=2.
- Burst with NUMBER_OF_SPI_FRAMES=2: send frame A then frame B with a 1023-cycle gap -> A lands in addresses 0..7, B in addresses 8..15, frame_index_o=1. Wait GAP_CYCLES, send frame C -> C overwrites bank 0.
- Partial byte: drop ss_n after 8 bytes plus 5 bits -> error_count increments and bank unchanged.
- Read/commit collision: issue a read of address 0 on the commit cycle -> old word returned; a repeated read returns the new word; waitrequest is high for exactly one cycle per read.
